// File: rtl/gpr_hilo_file.sv
// 32-entry GPR file plus HI/LO with ex > mem > wb > file read forwarding; REGFILE_WB_BYPASS_EN adds the wb level.
// Latency: writes land in stored state 1 cycle after the edge; reads and forwarding are combinational.
// Backpressure: none, writes and reads are accepted every cycle; rst forces all outputs to 0.
module gpr_hilo_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_wb_waddr,
    input  logic              i_wb_we,
    input  logic [DATA_W-1:0] i_wb_wdata,
    input  logic              i_wb_whi,
    input  logic              i_wb_wlo,
    input  logic [DATA_W-1:0] i_wb_hi,
    input  logic [DATA_W-1:0] i_wb_lo,
    input  logic [ADDR_W-1:0] i_ex_waddr,
    input  logic              i_ex_we,
    input  logic [DATA_W-1:0] i_ex_wdata,
    input  logic [ADDR_W-1:0] i_mem_waddr,
    input  logic              i_mem_we,
    input  logic [DATA_W-1:0] i_mem_wdata,
    input  logic              i_mem_whi,
    input  logic              i_mem_wlo,
    input  logic [DATA_W-1:0] i_mem_hi,
    input  logic [DATA_W-1:0] i_mem_lo,
    input  logic              i_re1,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic              i_re2,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic [1:0]        o_fwd_src1,
    output logic [1:0]        o_fwd_src2
);

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit WB_BYP = 1'b1;
`else
    localparam bit WB_BYP = 1'b0;
`endif

    logic [DATA_W-1:0] gpr_q [NREGS];
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    assign hi_d = i_wb_whi ? i_wb_hi : hi_q;
    assign lo_d = i_wb_wlo ? i_wb_lo : lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) gpr_q[i] <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            // r0 is hardwired to zero, so its writes are simply dropped
            if (i_wb_we && i_wb_waddr != '0) gpr_q[i_wb_waddr] <= i_wb_wdata;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Returns {src, data} for one read port.
    function automatic logic [DATA_W+1:0] resolve(input logic re, input logic [ADDR_W-1:0] ra);
        logic [DATA_W+1:0] res;
        res = '0;
        if (re && ra != '0) begin
            if (i_ex_we && i_ex_waddr == ra)
                res = {2'd3, i_ex_wdata};
            else if (i_mem_we && i_mem_waddr == ra)
                res = {2'd2, i_mem_wdata};
            else if (WB_BYP && i_wb_we && i_wb_waddr == ra)
                res = {2'd1, i_wb_wdata};
            else
                res = {2'd0, gpr_q[ra]};
        end
        return res;
    endfunction

    logic [DATA_W+1:0] rd1, rd2;
    logic [DATA_W-1:0] hi_fwd, lo_fwd;

    always_comb begin
        rd1 = resolve(i_re1, i_raddr1);
        rd2 = resolve(i_re2, i_raddr2);

        hi_fwd = hi_q;
        if (i_mem_whi)                hi_fwd = i_mem_hi;
        else if (WB_BYP && i_wb_whi)  hi_fwd = i_wb_hi;

        lo_fwd = lo_q;
        if (i_mem_wlo)                lo_fwd = i_mem_lo;
        else if (WB_BYP && i_wb_wlo)  lo_fwd = i_wb_lo;
    end

    assign o_rdata1   = rst ? '0 : rd1[DATA_W-1:0];
    assign o_rdata2   = rst ? '0 : rd2[DATA_W-1:0];
    assign o_fwd_src1 = rst ? '0 : rd1[DATA_W+1:DATA_W];
    assign o_fwd_src2 = rst ? '0 : rd2[DATA_W+1:DATA_W];
    assign o_hi       = rst ? '0 : hi_fwd;
    assign o_lo       = rst ? '0 : lo_fwd;

endmodule

// File: doc/gpr_hilo_file.md
Name: gpr_hilo_file

Overview:
- Architectural state block at the consuming end of the write-back path: 32-entry GPR file plus HI/LO registers.
- Writes come from the write-back stage registers (wb_waddr/we/wdata, whi/wlo/hi/lo).
- Supplies two GPR read ports to the decoder and HI/LO read values to the exec unit.
- Resolves read-after-write hazards by forwarding exec-stage and mem-stage backward results ahead of stored state.

Parameters:
- DATA_W, 32, data width; equals `REGBUS width.
- ADDR_W, 5, register address width; equals `REGADDRBUS width.
- NREGS, 32, number of GPR entries, 2**ADDR_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_wb_waddr  in  ADDR_W  write-back GPR address.
- i_wb_we  in  1  write-back GPR write enable.
- i_wb_wdata  in  DATA_W  write-back GPR data.
- i_wb_whi, i_wb_wlo  in  1 each  write-back HI/LO write enables.
- i_wb_hi, i_wb_lo  in  DATA_W each  write-back HI/LO data.
- i_ex_waddr, i_ex_we, i_ex_wdata  in  ADDR_W/1/DATA_W  exec-stage result forwarded backward.
- i_mem_waddr, i_mem_we, i_mem_wdata  in  ADDR_W/1/DATA_W  mem-stage backward GPR result.
- i_mem_whi, i_mem_wlo, i_mem_hi, i_mem_lo  in  1/1/DATA_W/DATA_W  mem-stage backward HI/LO.
- i_re1, i_raddr1  in  1/ADDR_W  read port 1 enable and address.
- i_re2, i_raddr2  in  1/ADDR_W  read port 2 enable and address.
- o_rdata1, o_rdata2  out  DATA_W each  read data.
- o_hi, o_lo  out  DATA_W each  forwarded HI/LO values for the exec unit.
- o_fwd_src1, o_fwd_src2  out  2 each  source of the read value: 0 = file, 1 = wb, 2 = mem, 3 = ex (debug/verification).

Behaviour:
- Reset: rst is asynchronous and active-high; the clock is clk.
  - All GPR entries, HI and LO clear to 0 immediately on rst.
  - While rst is high, o_rdata1/2, o_hi, o_lo and o_fwd_src1/2 are all 0 regardless of other inputs.
  - Reset mid-operation discards any write pending on that edge.
- Writes:
  - At posedge clk, when i_wb_we=1 and i_wb_waddr!=0, entry[i_wb_waddr] <= i_wb_wdata.
  - Writes to address 0 are dropped.
  - HI <= i_wb_hi when i_wb_whi=1; LO <= i_wb_lo when i_wb_wlo=1; HI and LO are independent.
  - Write latency is 1 cycle to stored state.
- GPR reads (combinational, evaluated independently per port n):
  - re=0: output 0, src 0.
  - raddr=0: output 0, src 0; no forwarding ever applies to r0.
  - Otherwise, priority is ex > mem > wb > file, with each level requiring we=1 and a matching address:
    - ex: i_ex_we=1 and i_ex_waddr==raddr gives i_ex_wdata, src 3.
    - mem: i_mem_we=1 and i_mem_waddr==raddr gives i_mem_wdata, src 2.
    - wb: i_wb_we=1 and i_wb_waddr==raddr gives i_wb_wdata, src 1 (only when REGFILE_WB_BYPASS_EN is defined).
    - Else: entry[raddr], src 0.
  - Both ports may read the same address and give identical results.
- HI/LO reads (combinational, HI and LO resolved independently):
  - o_hi = i_mem_hi if i_mem_whi, else i_wb_hi if i_wb_whi, else stored HI.
  - o_lo follows the same priority with the lo signals.
  - The wb level requires REGFILE_WB_BYPASS_EN; without it, o_hi/o_lo fall through from mem to stored.
- Simultaneous events:
  - A wb write and a read of the same register in one cycle: the stored value updates at the edge; the read result follows the bypass rule.
  - The ex/mem/wb priority rule always holds when several levels match.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: the wb level takes part in forwarding, as described above, for both GPR and HI/LO.
- Not defined: a same-cycle read of a register being written returns the old stored value; the value becomes visible the next cycle. In this build o_fwd_src never equals 1.

Test Plan:
- Reset, then read r5 and r0 with re=1 -> o_rdata 0; o_hi/o_lo 0; src 0; async assert mid-cycle clears outputs without waiting for a clock.
- wb write r7=0xDEADBEEF, next cycle read r7 -> 0xDEADBEEF, src 0; wb write r0=0x1234, then read r0 -> 0.
- Drive ex r3=0x11, mem r3=0x22, wb r3=0x33 together; read both ports at r3 -> 0x11, src 3. Drop ex -> 0x22, src 2. Drop mem -> 0x33, src 1 with macro; stored value, src 0 without.
- wb write r9=0xA5A5A5A5 and read r9 in the same cycle -> 0xA5A5A5A5 with macro, prior value 0 without; next cycle 0xA5A5A5A5 in both builds.
- Write HI=0x100 (whi only); then drive i_mem_whi=1, i_mem_hi=0x200 -> o_hi 0x200, o_lo unchanged 0; release mem -> o_hi 0x100.
- re1=0 with raddr1 matching an ex forward of 0xFF -> o_rdata1 0, src 0.
